// File: rtl/fyp_gen_pkg.sv
// fyp_gen_pkg
// Shared definitions for the fixed-format Ethernet frame generator:
// FSM state encoding, default header constants and the PRBS LFSR
// polynomial/seed used when the design is built with PRBS_PAYLOAD_EN.
package fyp_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } gen_state_t;

    localparam logic [47:0] DEFAULT_DST_MAC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] DEFAULT_SRC_MAC   = 48'h0215_1813_8300;
    localparam logic [15:0] DEFAULT_ETHERTYPE = 16'h88B5;

    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

    // Destination + source + EtherType.
    localparam int HDR_BYTES = 14;

endpackage

// File: rtl/fyp_gen_lfsr.sv
// fyp_gen_lfsr
// 32-bit Galois LFSR supplying pseudo-random payload words. Seeded on
// reset only; it advances one step per cycle with enable high.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high; loads LFSR_SEED
//   enable - advance one step
//   state  - current LFSR contents
module fyp_gen_lfsr
    import fyp_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LFSR_SEED;
        end else if (enable) begin
            state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/fyp_packet_generator.sv
// fyp_packet_generator
// Emits back-to-back fixed-length Ethernet frames (no FCS) on the MAC's
// Avalon-ST transmit port, with a fixed idle gap between frames.
// Push buttons start/stop the stream; a stop lets the current frame
// finish. The receive port is a drain-only sink.
// Build option: define PRBS_PAYLOAD_EN to take payload bytes from a
// 32-bit LFSR instead of the incrementing byte pattern.
// Ports:
//   clk, reset                      - 125 MHz clock, sync active-high reset
//   gen_start, gen_stop             - asynchronous push-button levels
//   eth_ast_tx_*                    - Avalon-ST source, ready latency 0
//   eth_ast_rx_* (inputs)           - ignored
//   eth_ast_rx_rdy                  - always 1
module fyp_packet_generator
    import fyp_gen_pkg::*;
#(
    parameter int          FRAME_BYTES = 60,
    parameter int          IPG_CYCLES  = 12,
    parameter logic [47:0] DST_MAC     = DEFAULT_DST_MAC,
    parameter logic [47:0] SRC_MAC     = DEFAULT_SRC_MAC,
    parameter logic [15:0] ETHERTYPE   = DEFAULT_ETHERTYPE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gen_start,
    input  logic        gen_stop,
    output logic [31:0] eth_ast_tx_data,
    output logic        eth_ast_tx_sop,
    output logic        eth_ast_tx_eop,
    output logic        eth_ast_tx_err,
    output logic [1:0]  eth_ast_tx_empty,
    output logic        eth_ast_tx_valid,
    input  logic        eth_ast_tx_rdy,
    input  logic [31:0] eth_ast_rx_data,
    input  logic        eth_ast_rx_sop,
    input  logic        eth_ast_rx_eop,
    input  logic        eth_ast_rx_valid,
    input  logic [5:0]  eth_ast_rx_err,
    input  logic [1:0]  eth_ast_rx_empty,
    output logic        eth_ast_rx_rdy
);

    localparam int           NUM_BEATS = (FRAME_BYTES + 3) / 4;
    localparam logic [8:0]   LAST_BEAT = 9'(NUM_BEATS - 1);
    localparam logic [1:0]   EOP_EMPTY = 2'((4 - FRAME_BYTES % 4) % 4);
    localparam logic [10:0]  FRAME_LEN = 11'(FRAME_BYTES);
    localparam logic [10:0]  HDR_LEN   = 11'(HDR_BYTES);
    localparam logic [111:0] HEADER    = {DST_MAC, SRC_MAC, ETHERTYPE};

    gen_state_t  state, state_next;
    logic        start_meta, start_sync, start_prev;
    logic        stop_meta, stop_sync, stop_prev;
    logic        start_pulse, stop_pulse;
    logic        running;
    logic [8:0]  beat_idx;
    logic [7:0]  gap_cnt;
    logic        tx_fire, last_beat, gap_done;
    logic [31:0] prbs_word;
    logic        unused_rx;

    assign start_pulse = start_sync & ~start_prev;
    assign stop_pulse  = stop_sync & ~stop_prev;
    assign tx_fire     = eth_ast_tx_valid & eth_ast_tx_rdy;
    assign last_beat   = (beat_idx == LAST_BEAT);
    assign gap_done    = (gap_cnt == 8'd0);

    assign eth_ast_rx_rdy = 1'b1;
    assign eth_ast_tx_err = 1'b0;
    assign unused_rx = ^{eth_ast_rx_data, eth_ast_rx_sop, eth_ast_rx_eop,
                         eth_ast_rx_valid, eth_ast_rx_err, eth_ast_rx_empty};

`ifdef PRBS_PAYLOAD_EN
    // Every beat from w3 onward carries payload, so each transfer of
    // one of them consumes one LFSR word.
    fyp_gen_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (tx_fire && (beat_idx >= 9'd3)),
        .state  (prbs_word)
    );
`else
    assign prbs_word = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
            stop_meta  <= 1'b0;
            stop_sync  <= 1'b0;
            stop_prev  <= 1'b0;
            running    <= 1'b0;
            beat_idx   <= 9'd0;
            gap_cnt    <= 8'd0;
        end else begin
            start_meta <= gen_start;
            start_sync <= start_meta;
            start_prev <= start_sync;
            stop_meta  <= gen_stop;
            stop_sync  <= stop_meta;
            stop_prev  <= stop_sync;

            // Stop has priority when both buttons edge in the same cycle.
            if (stop_pulse) begin
                running <= 1'b0;
            end else if (start_pulse) begin
                running <= 1'b1;
            end

            if (tx_fire) begin
                beat_idx <= last_beat ? 9'd0 : beat_idx + 9'd1;
            end

            // Loaded with IPG-1 so GAP lasts exactly IPG_CYCLES cycles.
            if (tx_fire && last_beat && (IPG_CYCLES > 0)) begin
                gap_cnt <= 8'(IPG_CYCLES - 1);
            end else if ((state == GAP) && !gap_done) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (running) state_next = SEND;
            SEND: begin
                if (tx_fire && last_beat) begin
                    if (IPG_CYCLES > 0) state_next = GAP;
                    else                state_next = running ? SEND : IDLE;
                end
            end
            GAP:  if (gap_done) state_next = running ? SEND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    function automatic logic [7:0] frame_byte(input logic [10:0] pos,
                                              input logic [7:0]  payload);
        if (pos < HDR_LEN)        return HEADER[8*(13 - int'(pos)) +: 8];
        else if (pos < FRAME_LEN) return payload;
        else                      return 8'h00;
    endfunction

    always_comb begin
        logic [10:0] pos;
        logic [7:0]  payload;
        eth_ast_tx_valid = (state == SEND);
        eth_ast_tx_sop   = eth_ast_tx_valid && (beat_idx == 9'd0);
        eth_ast_tx_eop   = eth_ast_tx_valid && last_beat;
        eth_ast_tx_empty = eth_ast_tx_eop ? EOP_EMPTY : 2'd0;
        eth_ast_tx_data  = 32'h0;
        pos              = 11'd0;
        payload          = 8'h00;
        if (eth_ast_tx_valid) begin
            for (int j = 0; j < 4; j++) begin
                pos = {beat_idx, 2'b00} + 11'(j);
`ifdef PRBS_PAYLOAD_EN
                payload = prbs_word[31 - 8*j -: 8];
`else
                payload = 8'(pos - HDR_LEN);
`endif
                eth_ast_tx_data[31 - 8*j -: 8] = frame_byte(pos, payload);
            end
        end
    end

endmodule

// File: tb/tb_fyp_packet_generator.sv
// Testbench for fyp_packet_generator: two instances (60- and 61-byte
// frames, 12-cycle gap) share all stimulus. Expected beats come from a
// byte-level frame model; line timing is derived from beats + gap.
module tb_fyp_packet_generator;
    import fyp_gen_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic gen_start = 1'b0;
    logic gen_stop = 1'b0;
    logic tx_rdy = 1'b1;
    logic [31:0] rx_data = 32'h0;
    logic rx_sop = 1'b0, rx_eop = 1'b0, rx_valid = 1'b0;
    logic [5:0] rx_err = 6'h0;
    logic [1:0] rx_empty = 2'h0;

    logic [31:0] d60, d61;
    logic sop60, sop61, eop60, eop61, err60, err61, val60, val61, rxr60, rxr61;
    logic [1:0] emp60, emp61;

    int n_cmp = 0;
    int n_err = 0;

    always #4 clk = ~clk;

    fyp_packet_generator #(.FRAME_BYTES(60), .IPG_CYCLES(12)) u60 (
        .clk(clk), .reset(reset), .gen_start(gen_start), .gen_stop(gen_stop),
        .eth_ast_tx_data(d60), .eth_ast_tx_sop(sop60), .eth_ast_tx_eop(eop60),
        .eth_ast_tx_err(err60), .eth_ast_tx_empty(emp60), .eth_ast_tx_valid(val60),
        .eth_ast_tx_rdy(tx_rdy), .eth_ast_rx_data(rx_data), .eth_ast_rx_sop(rx_sop),
        .eth_ast_rx_eop(rx_eop), .eth_ast_rx_valid(rx_valid), .eth_ast_rx_err(rx_err),
        .eth_ast_rx_empty(rx_empty), .eth_ast_rx_rdy(rxr60));

    fyp_packet_generator #(.FRAME_BYTES(61), .IPG_CYCLES(12)) u61 (
        .clk(clk), .reset(reset), .gen_start(gen_start), .gen_stop(gen_stop),
        .eth_ast_tx_data(d61), .eth_ast_tx_sop(sop61), .eth_ast_tx_eop(eop61),
        .eth_ast_tx_err(err61), .eth_ast_tx_empty(emp61), .eth_ast_tx_valid(val61),
        .eth_ast_tx_rdy(tx_rdy), .eth_ast_rx_data(rx_data), .eth_ast_rx_sop(rx_sop),
        .eth_ast_rx_eop(rx_eop), .eth_ast_rx_valid(rx_valid), .eth_ast_rx_err(rx_err),
        .eth_ast_rx_empty(rx_empty), .eth_ast_rx_rdy(rxr61));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte p of a frame: 14 header bytes, then payload byte k = k[7:0],
    // then zero padding up to the word boundary.
    function automatic logic [31:0] model_word(input int fb, input int beat);
        logic [111:0] hdr;
        logic [31:0]  w;
        int p;
        hdr = {48'hFFFF_FFFF_FFFF, 48'h0215_1813_8300, 16'h88B5};
        w = 32'h0;
        for (int j = 0; j < 4; j++) begin
            p = beat * 4 + j;
            if (p < 14)      w = {w[23:0], hdr[8*(13-p) +: 8]};
            else if (p < fb) w = {w[23:0], 8'(p - 14)};
            else             w = {w[23:0], 8'h00};
        end
        return w;
    endfunction

    // With PRBS payload only the header bytes are predictable here.
    function automatic logic [31:0] data_mask(input int beat);
`ifdef PRBS_PAYLOAD_EN
        if (beat < 3)  return 32'hFFFF_FFFF;
        if (beat == 3) return 32'hFFFF_0000;
        return 32'h0;
`else
        return 32'hFFFF_FFFF;
`endif
    endfunction

    // beat < 0 means the port must be idle.
    task automatic check_line(input string tag, input int fb, input int beat,
                              input logic v, input logic s, input logic e,
                              input logic [1:0] em, input logic [31:0] d);
        logic [36:0] exp_v;
        logic [31:0] m;
        int nb;
        nb = (fb + 3) / 4;
        if (beat < 0) begin
            exp_v = '0;
            m = 32'hFFFF_FFFF;
        end else begin
            m = data_mask(beat);
            exp_v = {1'b1, beat == 0, beat == nb - 1,
                     (beat == nb - 1) ? 2'((4 - fb % 4) % 4) : 2'd0,
                     model_word(fb, beat) & m};
        end
        check(tag, 64'({v, s, e, em, d & m}), 64'(exp_v));
    endtask

    initial begin
        int b60, b61, cnt60, cnt61;
        logic [31:0] w4_f1, w4_f2;
        w4_f1 = 32'h0;
        w4_f2 = 32'h0;

        // Reset state, including rx_rdy held high during reset.
        tick();
        tick();
        check("rst_out60", 64'({val60, sop60, eop60, emp60, d60, err60}), 64'h0);
        check("rst_out61", 64'({val61, sop61, eop61, emp61, d61, err61}), 64'h0);
        check("rst_rxrdy", 64'({rxr60, rxr61}), 64'h3);
        check("rst_state", 64'(u60.state), 64'(IDLE));
        reset = 1'b0;
        tick();

        // Start latency: valid after the 4th sampling edge.
        gen_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pre_sop_idle", 64'({val60, val61}), 64'h0);
        end
        tick();

        // Three frames at line rate; stop lands in frame 3.
        for (int i = 0; i < 112; i++) begin
            b60 = (i < 3*27 && (i % 27) < 15) ? (i % 27) : -1;
            b61 = (i < 3*28 && (i % 28) < 16) ? (i % 28) : -1;
            check_line("lineA60", 60, b60, val60, sop60, eop60, emp60, d60);
            check_line("lineA61", 61, b61, val61, sop61, eop61, emp61, d61);
            if (i == 0) check("w0", 64'(d60), 64'h0000_0000_FFFF_FFFF);
            if (i == 3) begin
`ifdef PRBS_PAYLOAD_EN
                check("w3", 64'(d60), 64'h0000_0000_88B5_FFFF);
`else
                check("w3", 64'(d60), 64'h0000_0000_88B5_0001);
`endif
            end
            if (i == 14) check("eop60", 64'({eop60, emp60}), 64'h4);
            if (i == 15) begin
                // Last byte of a 61-byte frame is payload index 46 (8'h2E).
`ifndef PRBS_PAYLOAD_EN
                check("eop61_data", 64'(d61), 64'h0000_0000_2E00_0000);
`endif
                check("eop61_flags", 64'({eop61, emp61}), 64'h7);
            end
            if (i % 10 == 0) check("rx_rdy", 64'({rxr60, rxr61, err60, err61}), 64'hC);
            if (i == 4)  w4_f1 = d60;
            if (i == 31) w4_f2 = d60;
            if (i == 5)  gen_start = 1'b0;
            if (i == 60) gen_stop = 1'b1;
            if (i == 63) gen_stop = 1'b0;
            tick();
        end
        check("stopped_idle", 64'(u60.state), 64'(IDLE));
`ifdef PRBS_PAYLOAD_EN
        check("prbs_differs", 64'(w4_f1 != w4_f2), 64'h1);
`else
        check("w4_repeat", 64'(w4_f2), 64'(w4_f1));
`endif

        // Random backpressure on one frame: outputs must follow the model
        // beat index, which only advances on accepted beats.
        cnt60 = 0;
        cnt61 = 0;
        gen_start = 1'b1;
        for (int c = 0; c < 150; c++) begin
            tx_rdy = 1'($urandom_range(0, 1));
            b60 = (c >= 4 && cnt60 < 15) ? cnt60 : -1;
            b61 = (c >= 4 && cnt61 < 16) ? cnt61 : -1;
            check_line("bp60", 60, b60, val60, sop60, eop60, emp60, d60);
            check_line("bp61", 61, b61, val61, sop61, eop61, emp61, d61);
            if (b60 >= 0 && tx_rdy) cnt60++;
            if (b61 >= 0 && tx_rdy) cnt61++;
            if (c == 3) gen_start = 1'b0;
            if (c == 5) gen_stop = 1'b1;
            if (c == 8) gen_stop = 1'b0;
            tick();
        end
        check("bp_beats60", 64'(cnt60), 64'd15);
        check("bp_beats61", 64'(cnt61), 64'd16);
        tx_rdy = 1'b1;

        // Start and stop together: stop wins.
        gen_start = 1'b1;
        gen_stop = 1'b1;
        tick(); tick(); tick();
        gen_start = 1'b0;
        gen_stop = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("both_idle", 64'({val60, val61}), 64'h0);
            tick();
        end

        // Mid-frame reset abandons the frame and clears running.
        gen_start = 1'b1;
        tick(); tick(); tick();
        gen_start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("midframe_valid", 64'({val60, val61}), 64'h3);
        reset = 1'b1;
        tick();
        check("reset_drop", 64'({val60, val61, d60, d61}), 64'h0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post_reset_idle", 64'({val60, val61}), 64'h0);
        end

        // Full frame after reset.
        gen_start = 1'b1;
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 20; i++) begin
            check_line("lineD60", 60, (i < 15) ? i : -1, val60, sop60, eop60, emp60, d60);
            check_line("lineD61", 61, (i < 16) ? i : -1, val61, sop61, eop61, emp61, d61);
            if (i == 3) gen_start = 1'b0;
            if (i == 6) gen_stop = 1'b1;
            if (i == 9) gen_stop = 1'b0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
